// File: rtl/mem_ctrl.sv
// mem_ctrl -- CPU memory map controller with optional OAM DMA engine.
//
// Address map seen by the CPU:
//   0000-7FFF cartridge ROM (read-only, data comes back combinationally)
//   C000-DFFF work RAM 8 KiB, E000-FDFF echoes C000-DDFF
//   FE00-FE9F OAM, FF46 DMA source page register, FF80-FFFE HRAM, FFFF IE
//   anything else reads 0xFF and ignores writes.
//
// Build option: define MEM_CTRL_OAM_DMA_EN to include the OAM DMA engine.
// Without it FF46 is a plain read/write register and o_dma_active is 0.
//
// Ports:
//   i_clk, i_rst_n                        clock, synchronous active-low reset
//   i_cpu_rd_addr / o_cpu_rd_data         CPU read, data registered (1 clock)
//   i_cpu_wr_en/_addr/_data               single-cycle CPU write
//   o_rom_addr / i_rom_data               ROM port (CPU address or DMA source)
//   o_dma_active                          DMA pending or transferring
module mem_ctrl #(
    parameter int unsigned DMA_BYTE_CLKS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_cpu_rd_addr,
    output logic [7:0]  o_cpu_rd_data,
    input  logic        i_cpu_wr_en,
    input  logic [15:0] i_cpu_wr_addr,
    input  logic [7:0]  i_cpu_wr_data,
    output logic [14:0] o_rom_addr,
    input  logic [7:0]  i_rom_data,
    output logic        o_dma_active
);

    typedef enum logic [2:0] {
        RG_NONE, RG_ROM, RG_WRAM, RG_OAM, RG_DMA, RG_HRAM, RG_IE
    } region_e;

    function automatic region_e decode_addr(input logic [15:0] addr);
        region_e rg;
        rg = RG_NONE;
        if (addr[15] == 1'b0)                            rg = RG_ROM;
        else if (addr >= 16'hC000 && addr <= 16'hFDFF)   rg = RG_WRAM;
        else if (addr >= 16'hFE00 && addr <= 16'hFE9F)   rg = RG_OAM;
        else if (addr == 16'hFF46)                       rg = RG_DMA;
        else if (addr >= 16'hFF80 && addr <= 16'hFFFE)   rg = RG_HRAM;
        else if (addr == 16'hFFFF)                       rg = RG_IE;
        return rg;
    endfunction

    logic [7:0] wram_mem [0:8191];
    logic [7:0] hram_mem [0:126];
    logic [7:0] oam_mem  [0:159];

    logic [7:0]  rd_data_q, rd_data_d;
    logic [7:0]  dma_reg_q, dma_reg_d;
    logic [7:0]  ie_q, ie_d;

    region_e     rd_region, wr_region;
    logic        cpu_blocked, dma_xfer, dma_oam_we;
    logic [7:0]  dma_oam_idx, dma_oam_data;
    logic [14:0] dma_rom_addr;
    logic        cpu_wr_ok, ff46_wr;
    logic        oam_we;
    logic [7:0]  oam_wr_idx, oam_wr_data;

    assign rd_region = decode_addr(i_cpu_rd_addr);
    assign wr_region = decode_addr(i_cpu_wr_addr);

    // While a transfer owns the bus only HRAM and the DMA register stay writable.
    assign cpu_wr_ok = i_cpu_wr_en &&
                       (!cpu_blocked || wr_region == RG_HRAM || wr_region == RG_DMA);
    assign ff46_wr   = cpu_wr_ok && (wr_region == RG_DMA);

`ifdef MEM_CTRL_OAM_DMA_EN
    localparam int unsigned CNT_W = (DMA_BYTE_CLKS > 1) ? $clog2(DMA_BYTE_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMA_BYTE_CLKS - 1);

    typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_XFER} dma_state_e;

    dma_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       page_q, page_d;   // source page with echo folded back
    logic [7:0]       byte_q, byte_d;   // source byte captured on first clock
    logic             dma_active_q, dma_active_d;
    logic [7:0]       dma_src_data;

    assign dma_xfer     = (state_q == DMA_XFER);
    assign cpu_blocked  = dma_xfer;
    assign dma_rom_addr = {page_q[6:0], idx_q};
    assign dma_oam_idx  = idx_q;
    assign o_dma_active = dma_active_q;

    always_comb begin
        if (page_q[7] == 1'b0)           dma_src_data = i_rom_data;
        else if (page_q[7:5] == 3'b110)  dma_src_data = wram_mem[{page_q[4:0], idx_q}];
        else                             dma_src_data = 8'hFF;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        page_d     = page_q;
        byte_d     = byte_q;
        dma_oam_we = 1'b0;
        // With one clock per byte the capture and the OAM write coincide.
        dma_oam_data = (cnt_q == '0) ? dma_src_data : byte_q;
        case (state_q)
            DMA_START: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DMA_XFER;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DMA_XFER: begin
                if (cnt_q == '0) byte_d = dma_src_data;
                if (cnt_q == CNT_LAST) begin
                    dma_oam_we = 1'b1;
                    cnt_d      = '0;
                    if (idx_q == 8'd159) begin
                        state_d = DMA_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        // A register write always (re)starts from the top, whatever the state.
        if (ff46_wr) begin
            state_d = DMA_START;
            cnt_d   = '0;
            idx_d   = '0;
            page_d  = (i_cpu_wr_data >= 8'hE0) ? (i_cpu_wr_data - 8'h20) : i_cpu_wr_data;
        end
        dma_active_d = (state_d != DMA_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= DMA_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            page_q       <= '0;
            byte_q       <= '0;
            dma_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            page_q       <= page_d;
            byte_q       <= byte_d;
            dma_active_q <= dma_active_d;
        end
    end
`else
    assign dma_xfer     = 1'b0;
    assign cpu_blocked  = 1'b0;
    assign dma_oam_we   = 1'b0;
    assign dma_oam_idx  = '0;
    assign dma_oam_data = '0;
    assign dma_rom_addr = '0;
    assign o_dma_active = 1'b0;
`endif

    // ROM data is combinational, so the address must follow the CPU directly.
    assign o_rom_addr = (!i_rst_n) ? 15'd0 :
                        (dma_xfer ? dma_rom_addr : i_cpu_rd_addr[14:0]);

    // Single OAM write port; the DMA engine wins any collision.
    always_comb begin
        oam_we      = 1'b0;
        oam_wr_idx  = i_cpu_wr_addr[7:0];
        oam_wr_data = i_cpu_wr_data;
        if (dma_oam_we) begin
            oam_we      = 1'b1;
            oam_wr_idx  = dma_oam_idx;
            oam_wr_data = dma_oam_data;
        end else if (cpu_wr_ok && wr_region == RG_OAM) begin
            oam_we = 1'b1;
        end
    end

    // Memory contents survive reset; only writes are suppressed while it is held.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && cpu_wr_ok && wr_region == RG_WRAM)
            wram_mem[i_cpu_wr_addr[12:0]] <= i_cpu_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && cpu_wr_ok && wr_region == RG_HRAM)
            hram_mem[i_cpu_wr_addr[6:0]] <= i_cpu_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && oam_we)
            oam_mem[oam_wr_idx] <= oam_wr_data;
    end

    always_comb begin
        dma_reg_d = dma_reg_q;
        ie_d      = ie_q;
        if (ff46_wr) dma_reg_d = i_cpu_wr_data;
        if (cpu_wr_ok && wr_region == RG_IE) ie_d = i_cpu_wr_data;

        rd_data_d = 8'hFF;
        case (rd_region)
            RG_ROM:  rd_data_d = i_rom_data;
            RG_WRAM: rd_data_d = wram_mem[i_cpu_rd_addr[12:0]];
            RG_OAM:  rd_data_d = oam_mem[i_cpu_rd_addr[7:0]];
            RG_DMA:  rd_data_d = dma_reg_q;
            RG_HRAM: rd_data_d = hram_mem[i_cpu_rd_addr[6:0]];
            RG_IE:   rd_data_d = ie_q;
            default: rd_data_d = 8'hFF;
        endcase
        if (cpu_blocked && rd_region != RG_HRAM) rd_data_d = 8'hFF;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_data_q <= 8'hFF;
            dma_reg_q <= 8'h00;
            ie_q      <= 8'h00;
        end else begin
            rd_data_q <= rd_data_d;
            dma_reg_q <= dma_reg_d;
            ie_q      <= ie_d;
        end
    end

    assign o_cpu_rd_data = rd_data_q;

endmodule
